narrow_ser: RTL and testbench

- Width-narrowing serializer: the inverse direction of the zero-extension path.
- Accepts one bus_size-wide word and emits it as bus_size_out-wide chunks, LSB chunk first, over a valid/ready stream.
- Truncate mode emits only the low chunk and flags any nonzero discarded upper bits (i.e. the value was not a zero-extension).
- Sits between wide datapath registers and narrower memory/IO lanes.

---
 rtl/narrow_ser.sv | 93 +++++++++
 tb/tb_narrow_ser.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/narrow_ser.sv
// Width-narrowing serializer: takes one bus_size-wide word and emits it as
// bus_size_out-wide chunks, LSB chunk first. Truncate mode sends only the low chunk.
module narrow_ser #(
    parameter int bus_size     = 8,
    parameter int bus_size_out = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [bus_size-1:0]     in,
    input  logic                    trunc,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [bus_size_out-1:0] out,
    output logic                    out_last,
    output logic                    trunc_err
);

    localparam int N  = bus_size / bus_size_out;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    localparam logic [CW-1:0] LAST_FULL = CW'(N - 1);

    logic [0:0]          state_q,     state_d;
    logic [bus_size-1:0] shreg_q,     shreg_d;
    logic [CW-1:0]       cnt_q,       cnt_d;
    logic [CW-1:0]       last_idx_q,  last_idx_d;
    logic                trunc_err_q, trunc_err_d;

    logic at_last;
    assign at_last = (cnt_q == last_idx_q);

    // NOTE: every next-state signal gets a default first so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        last_idx_d  = last_idx_q;
        trunc_err_d = trunc_err_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    shreg_d     = in;
                    cnt_d       = '0;
                    last_idx_d  = trunc ? '0 : LAST_FULL;
                    // Upper bits nonzero means the word was not a zero-extension.
                    trunc_err_d = trunc && (in[bus_size-1:bus_size_out] != '0);
                    state_d     = SEND;
                end
            end
            SEND: begin
                if (out_ready) begin
                    if (at_last) begin
                        state_d     = IDLE;
                        trunc_err_d = 1'b0;
                    end else begin
                        shreg_d = shreg_q >> bus_size_out;
                        cnt_d   = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            cnt_q       <= '0;
            last_idx_q  <= '0;
            trunc_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            last_idx_q  <= last_idx_d;
            trunc_err_q <= trunc_err_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == SEND);
    assign out       = shreg_q[bus_size_out-1:0];
    assign out_last  = out_valid && at_last;
    assign trunc_err = trunc_err_q;

endmodule

// File: tb/tb_narrow_ser.sv
// Directed bench for narrow_ser: 8->4 instance for most cases, 32->8 instance
// for the wide word and the no-overlap check.
module tb_narrow_ser;

    logic clk;
    logic rst_n;

    // 8 -> 4 instance
    logic       a_in_valid, a_in_ready, a_trunc, a_out_valid, a_out_ready, a_out_last, a_trunc_err;
    logic [7:0] a_in;
    logic [3:0] a_out;

    // 32 -> 8 instance
    logic        b_in_valid, b_in_ready, b_trunc, b_out_valid, b_out_ready, b_out_last, b_trunc_err;
    logic [31:0] b_in;
    logic [7:0]  b_out;

    int tests_run;
    int tests_failed;
    int a_handshakes;
    int a_bad_beats;

    narrow_ser #(.bus_size(8), .bus_size_out(4)) u_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in        (a_in),
        .trunc     (a_trunc),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out       (a_out),
        .out_last  (a_out_last),
        .trunc_err (a_trunc_err)
    );

    narrow_ser #(.bus_size(32), .bus_size_out(8)) u_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in        (b_in),
        .trunc     (b_trunc),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out       (b_out),
        .out_last  (b_out_last),
        .trunc_err (b_trunc_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (a_out_valid && a_out_ready) a_handshakes++;
        if (a_out_valid && a_out == 4'hA) a_bad_beats++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        a_handshakes = 0;
        a_bad_beats  = 0;
        rst_n        = 1'b0;
        a_in_valid = 1'b0; a_in = '0; a_trunc = 1'b0; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_in = '0; b_trunc = 1'b0; b_out_ready = 1'b0;
        step();
        step();

        // Reset state
        check("rst_in_ready",  a_in_ready,  1);
        check("rst_out_valid", a_out_valid, 0);
        check("rst_out",       a_out,       0);
        check("rst_out_last",  a_out_last,  0);
        check("rst_trunc_err", a_trunc_err, 0);
        rst_n = 1'b1;
        step();

        // Normal mode, 8'hA5
        a_in = 8'hA5; a_trunc = 1'b0; a_in_valid = 1'b1; a_out_ready = 1'b1;
        check("n_in_ready_pre", a_in_ready, 1);
        step();
        a_in_valid = 1'b0;
        check("n_in_ready_busy", a_in_ready,  0);
        check("n_b0_valid",      a_out_valid, 1);
        check("n_b0_data",       a_out,       4'h5);
        check("n_b0_last",       a_out_last,  0);
        check("n_b0_err",        a_trunc_err, 0);
        step();
        check("n_b1_valid", a_out_valid, 1);
        check("n_b1_data",  a_out,       4'hA);
        check("n_b1_last",  a_out_last,  1);
        check("n_b1_err",   a_trunc_err, 0);
        step();
        check("n_idle_ready", a_in_ready,  1);
        check("n_idle_valid", a_out_valid, 0);
        check("n_idle_last",  a_out_last,  0);

        // Truncate mode, clean upper bits
        a_in = 8'h05; a_trunc = 1'b1; a_in_valid = 1'b1;
        step();
        a_in_valid = 1'b0;
        check("t05_data", a_out,       4'h5);
        check("t05_last", a_out_last,  1);
        check("t05_err",  a_trunc_err, 0);
        step();
        check("t05_idle", a_in_ready, 1);

        // Truncate mode, dirty upper bits
        a_in = 8'h35; a_trunc = 1'b1; a_in_valid = 1'b1;
        step();
        a_in_valid = 1'b0;
        check("t35_data", a_out,       4'h5);
        check("t35_last", a_out_last,  1);
        check("t35_err",  a_trunc_err, 1);
        step();
        check("t35_err_clr", a_trunc_err, 0);
        check("t35_idle",    a_out_valid, 0);

        // Backpressure, 8'h3C with out_ready low for three cycles
        a_handshakes = 0;
        a_in = 8'h3C; a_trunc = 1'b0; a_in_valid = 1'b1; a_out_ready = 1'b0;
        step();
        a_in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("bp_hold_data", a_out,      4'hC);
            check("bp_hold_last", a_out_last, 0);
            step();
        end
        a_out_ready = 1'b1;
        check("bp_fourth_data", a_out, 4'hC);
        step();
        check("bp_b1_data", a_out,      4'h3);
        check("bp_b1_last", a_out_last, 1);
        step();
        check("bp_idle",       a_out_valid,  0);
        check("bp_handshakes", a_handshakes, 2);

        // Wide instance, second word offered during SEND
        b_in = 32'h12345678; b_trunc = 1'b0; b_in_valid = 1'b1; b_out_ready = 1'b1;
        step();
        b_in = 32'hDEADBEEF;
        begin
            logic [31:0] exp_b [4];
            exp_b[0] = 32'h78; exp_b[1] = 32'h56; exp_b[2] = 32'h34; exp_b[3] = 32'h12;
            for (int i = 0; i < 4; i++) begin
                check("w_busy",  b_in_ready, 0);
                check("w_data",  b_out,      exp_b[i]);
                check("w_last",  b_out_last, (i == 3) ? 1 : 0);
                check("w_err",   b_trunc_err, 0);
                step();
            end
        end
        check("w_idle_ready", b_in_ready,  1);
        check("w_idle_valid", b_out_valid, 0);
        step();
        b_in_valid = 1'b0;
        check("w2_first", b_out, 8'hEF);
        begin
            logic [31:0] exp_c [3];
            exp_c[0] = 32'hBE; exp_c[1] = 32'hAD; exp_c[2] = 32'hDE;
            for (int i = 0; i < 3; i++) begin
                step();
                check("w2_data", b_out, exp_c[i]);
            end
        end
        check("w2_last", b_out_last, 1);
        step();
        check("w2_idle", b_out_valid, 0);

        // Reset mid-word after the first beat of 8'hA5
        a_bad_beats = 0;
        a_in = 8'hA5; a_trunc = 1'b0; a_in_valid = 1'b1; a_out_ready = 1'b1;
        step();
        a_in_valid = 1'b0;
        check("r_b0_data", a_out, 4'h5);
        @(posedge clk);
        #1;
        a_bad_beats = 0;
        a_out_ready = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check("r_async_valid", a_out_valid, 0);
        check("r_async_out",   a_out,       0);
        step();
        rst_n = 1'b1;
        a_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("r_post_ready", a_in_ready,  1);
            check("r_post_valid", a_out_valid, 0);
        end
        check("r_no_A_beat", a_bad_beats, 0);

        // Round trip: 4'b0101 zero-extended and truncated back
        begin
            logic [3:0] nib;
            nib = 4'b0101;
            a_in = {4'b0000, nib}; a_trunc = 1'b1; a_in_valid = 1'b1;
            step();
            a_in_valid = 1'b0;
            check("rt_data", a_out,       nib);
            check("rt_err",  a_trunc_err, 0);
            check("rt_last", a_out_last,  1);
            step();
            check("rt_idle", a_in_ready, 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
